// File: rtl/perf_monitor.sv
// Run-control and performance-counter unit: counts run cycles and NUM_EV event channels
// between a start pulse and a stop edge or watchdog timeout, then freezes the results.
module perf_monitor #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned NUM_EV  = 2,
    parameter int unsigned TIMEOUT = 1000,
    parameter int unsigned SEL_W   = 1
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic [NUM_EV-1:0] event_in,
    input  logic [SEL_W-1:0]  ev_sel,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [CNT_W-1:0]  ev_count,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic              overflow
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone,
        StTimeout
    } state_e;

    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] CntSat = CntMax - 1'b1;
    localparam logic [CNT_W-1:0] ToLast = CNT_W'(TIMEOUT - 1);

    state_e                        state_q, state_d;
    logic   [CNT_W-1:0]            cyc_q, cyc_d;
    logic   [NUM_EV-1:0][CNT_W-1:0] ev_q, ev_d;
    logic                          ovf_q, ovf_d;
    logic                          stop_q;
    logic                          stop_edge;

    assign stop_edge = stop & ~stop_q;

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        ev_d    = ev_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            StRun: begin
                if (start) begin
                    cyc_d = '0;
                    ev_d  = '0;
                    ovf_d = 1'b0;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                    // Overflow flags any increment that leaves a counter at full scale.
                    for (int i = 0; i < int'(NUM_EV); i++) begin
                        if (event_in[i]) begin
                            if (ev_q[i] != CntMax) begin
                                ev_d[i] = ev_q[i] + 1'b1;
                            end
                            if (ev_q[i] >= CntSat) begin
                                ovf_d = 1'b1;
                            end
                        end
                    end
                    if (stop_edge) begin
                        state_d = StDone;
                    end else if (cyc_q == ToLast) begin
                        state_d = StTimeout;
                    end
                end
            end
            default: begin
                if (start) begin
                    cyc_d   = '0;
                    ev_d    = '0;
                    ovf_d   = 1'b0;
                    state_d = StRun;
                end
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cyc_q   <= '0;
            ev_q    <= '0;
            ovf_q   <= 1'b0;
            stop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            ev_q    <= ev_d;
            ovf_q   <= ovf_d;
            stop_q  <= stop;
        end
    end

    always_comb begin
        ev_count = '0;
        for (int i = 0; i < int'(NUM_EV); i++) begin
            if (ev_sel == SEL_W'(i)) begin
                ev_count = ev_q[i];
            end
        end
    end

    assign cycle_count = cyc_q;
    assign overflow    = ovf_q;
    assign busy        = (state_q == StRun);
    assign done        = (state_q == StDone);
    assign timeout     = (state_q == StTimeout);

endmodule

// File: tb/tb_perf_monitor.sv
// Scoreboard bench for perf_monitor: the driver runs a spec-level model and queues the
// expected result of each run; a monitor pops it when done/timeout rises.
module tb_perf_monitor;

    localparam int unsigned CNT_W   = 4;
    localparam int unsigned NUM_EV  = 3;
    localparam int unsigned TIMEOUT = 15;
    localparam int unsigned SEL_W   = 2;
    localparam int          MAXV    = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic [NUM_EV-1:0] event_in = '0;
    logic [SEL_W-1:0]  ev_sel = '0;
    logic [CNT_W-1:0]  cycle_count;
    logic [CNT_W-1:0]  ev_count;
    logic              busy;
    logic              done;
    logic              timeout;
    logic              overflow;

    perf_monitor #(
        .CNT_W  (CNT_W),
        .NUM_EV (NUM_EV),
        .TIMEOUT(TIMEOUT),
        .SEL_W  (SEL_W)
    ) dut (
        .CLOCK_50   (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .event_in   (event_in),
        .ev_sel     (ev_sel),
        .cycle_count(cycle_count),
        .ev_count   (ev_count),
        .busy       (busy),
        .done       (done),
        .timeout    (timeout),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]                     cyc;
        logic [NUM_EV-1:0][CNT_W-1:0]   ev;
        logic                           ovf;
        logic                           to;
    } exp_t;

    exp_t exp_q[$];

    int n_vec = 0;
    int n_err = 0;

    // Spec-level model state.
    bit m_running = 0;
    bit m_prev_stop = 0;
    bit m_ovf = 0;
    int m_cyc = 0;
    int m_ev[NUM_EV];

    task automatic check(input string name, input int act, input int expv);
        n_vec++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic void model_clear();
        m_cyc = 0;
        m_ovf = 0;
        for (int i = 0; i < int'(NUM_EV); i++) m_ev[i] = 0;
    endfunction

    function automatic void model_finish(input bit to);
        exp_t e;
        e.cyc = 8'(m_cyc);
        e.ovf = m_ovf;
        e.to  = to;
        for (int i = 0; i < int'(NUM_EV); i++) e.ev[i] = CNT_W'(m_ev[i]);
        exp_q.push_back(e);
        m_running = 0;
    endfunction

    function automatic void model_step(input bit s, input bit p, input logic [NUM_EV-1:0] e);
        bit rose;
        rose = p && !m_prev_stop;
        m_prev_stop = p;
        if (!m_running) begin
            if (s) begin
                model_clear();
                m_running = 1;
            end
        end else if (s) begin
            model_clear();
        end else begin
            m_cyc++;
            for (int i = 0; i < int'(NUM_EV); i++) begin
                if (e[i] && m_ev[i] < MAXV) m_ev[i]++;
                if (m_ev[i] == MAXV) m_ovf = 1;
            end
            if (rose) model_finish(0);
            else if (m_cyc == int'(TIMEOUT)) model_finish(1);
        end
    endfunction

    task automatic step(input bit s, input bit p, input logic [NUM_EV-1:0] e);
        start    = s;
        stop     = p;
        event_in = e;
        @(posedge clk);
        model_step(s, p, e);
        #1;
        start = 1'b0;
    endtask

    function automatic logic [NUM_EV-1:0] rnd_ev();
        return NUM_EV'($urandom);
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_cycle_count"}, int'(cycle_count), 0);
        check({tag, "_ev_count"}, int'(ev_count), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_timeout"}, int'(timeout), 0);
        check({tag, "_overflow"}, int'(overflow), 0);
    endtask

    // Monitor: per-cycle run tracking plus scoreboard pop on each termination.
    initial begin
        bit   prev_term;
        bit   have_cur;
        bit   term;
        exp_t cur;
        prev_term = 0;
        have_cur  = 0;
        cur       = '0;
        forever begin
            @(negedge clk);
            check("busy", int'(busy), int'(m_running));
            if (m_running) begin
                check("run_cycle_count", int'(cycle_count), m_cyc);
                check("run_overflow", int'(overflow), int'(m_ovf));
            end
            term = done | timeout;
            if (term && !prev_term) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_end", 1, 0);
                    have_cur = 0;
                end else begin
                    cur      = exp_q.pop_front();
                    have_cur = 1;
                end
            end
            if (term && have_cur) begin
                check("end_cycle_count", int'(cycle_count), int'(cur.cyc));
                check("end_done", int'(done), int'(!cur.to));
                check("end_timeout", int'(timeout), int'(cur.to));
                check("end_overflow", int'(overflow), int'(cur.ovf));
                for (int s = 0; s < (1 << SEL_W); s++) begin
                    ev_sel = SEL_W'(s);
                    #1;
                    check($sformatf("end_ev%0d", s), int'(ev_count),
                          (s < int'(NUM_EV)) ? int'(cur.ev[s]) : 0);
                end
            end
            if (!term) have_cur = 0;
            prev_term = term;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #3;
        check_all_zero("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(0, 0, '0);

        // Basic run: event 0 on 7 of 10 cycles, stop rises in the 10th.
        step(1, 0, '0);
        for (int k = 0; k < 10; k++) begin
            logic [9:0] pat;
            pat = 10'b1011011011;
            step(0, (k == 9), {2'b00, pat[k]});
        end
        for (int k = 0; k < 20; k++) step(0, 1'($urandom), rnd_ev());

        // Plain timeout.
        step(0, 0, '0);
        step(1, 0, '0);
        for (int k = 0; k < int'(TIMEOUT); k++) step(0, 0, rnd_ev());
        step(0, 0, rnd_ev());

        // Stop edge in the last allowed cycle: done wins.
        step(1, 0, '0);
        for (int k = 0; k < int'(TIMEOUT); k++) step(0, (k == int'(TIMEOUT) - 1), rnd_ev());
        step(0, 0, '0);

        // Saturation of channel 1, then a new start clears overflow.
        step(1, 0, '0);
        for (int k = 0; k < 20; k++) step(0, 0, 3'b010);
        step(1, 0, '0);
        for (int k = 0; k < 3; k++) step(0, 0, 3'b001);
        step(0, 1, '0);
        step(0, 0, '0);

        // Restart in RUN with stop held high from before the start.
        step(0, 1, '0);
        step(1, 1, rnd_ev());
        for (int k = 0; k < 4; k++) step(0, 1, rnd_ev());
        step(1, 1, 3'b111);
        for (int k = 0; k < 6; k++) step(0, 1, rnd_ev());
        step(0, 0, rnd_ev());
        step(0, 1, rnd_ev());
        step(0, 0, '0);

        // Asynchronous reset mid-run.
        step(1, 0, '0);
        for (int k = 0; k < 5; k++) step(0, 0, 3'b111);
        reset       = 1'b1;
        m_running   = 0;
        m_prev_stop = 0;
        model_clear();
        #1;
        check_all_zero("midrun_reset");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Randomised runs with occasional restarts and stop toggling.
        for (int r = 0; r < 40; r++) begin
            int budget;
            bit p;
            p = 1'($urandom);
            step(1, p, rnd_ev());
            budget = 0;
            while (m_running && budget < 200) begin
                if ($urandom_range(0, 3) == 0) p = ~p;
                step(($urandom_range(0, 29) == 0), p, rnd_ev());
                budget++;
            end
            if (m_running) check("run_terminates", 0, 1);
            for (int k = 0; k < int'($urandom_range(1, 4)); k++) step(0, p, rnd_ev());
        end

        step(0, 0, '0);
        step(0, 0, '0);
        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
